// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//
// Plays a programmed sequence of notes. A small pattern RAM holds
// (tone, beats) entries. The sequencer steps through the entries, drives each
// tone code to the tone generator, and gates the audio with note_on. Each note
// lasts beats*BEAT_TICKS cycles and is followed by a silent gap of GAP_TICKS
// cycles. Playback can be one-shot or looping.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     pattern write strobe (accepted in any state)
//   wr_addr   pattern entry index
//   wr_tone   tone code stored in the entry
//   wr_beats  note length in beats; 0 marks the end of the pattern
//   length    number of entries to play (1..16, larger values clamp to 16,
//             0 makes start finish immediately with a done pulse)
//   loop_en   restart at entry 0 after the last entry
//   start     1-cycle start request (ignored while busy)
//   stop      1-cycle abort request (beats start in the same cycle)
//   tone      tone code to the tone generator
//   note_on   high while a note sounds
//   busy      high while playing a note or its gap
//   step      index of the current entry
//   done      1-cycle pulse on the natural end of a one-shot sequence
// ---------------------------------------------------------------------------
module melody_sequencer #(
  parameter logic [31:0] CLOCK_SPEED = 32'd25_000_000,
  parameter logic [31:0] BEAT_TICKS  = 32'd3_125_000,
  parameter logic [31:0] GAP_TICKS   = 32'd250_000,
  parameter int          DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_tone,
  input  logic [3:0] wr_beats,
  input  logic [4:0] length,
  input  logic       loop_en,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] tone,
  output logic       note_on,
  output logic       busy,
  output logic [3:0] step,
  output logic       done
);

  // CLOCK_SPEED only documents how BEAT_TICKS was derived. The guard below
  // rejects parameter sets the fixed 4-bit address ports cannot support.
  if (BEAT_TICKS == 32'd0 || CLOCK_SPEED == 32'd0 || DEPTH < 1 || DEPTH > 16) begin : g_param_check
    $error("melody_sequencer: BEAT_TICKS/CLOCK_SPEED must be nonzero and DEPTH in 1..16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [4:0]  MAX_LEN  = 5'(DEPTH);
  localparam bit          HAS_GAP  = (GAP_TICKS != 32'd0);
  // The gap counter counts down to zero, so it is loaded with one less than
  // the gap length. When there is no gap this value is never used.
  localparam logic [35:0] GAP_LOAD = {4'd0, GAP_TICKS} - 36'd1;

  state_t      state;
  logic [35:0] counter;
  logic [4:0]  play_len;

  logic [3:0]  ram_tone  [DEPTH];
  logic [3:0]  ram_beats [DEPTH];

  logic [4:0]  len_clamped;
  logic [3:0]  next_step;
  logic        is_last;
  logic        note_end;
  logic        advance_now;
  logic        adv_continue;
  logic [3:0]  adv_step;

  // A note of n beats lasts n*BEAT_TICKS cycles. The counter is loaded with
  // one less so that the cycle it reads zero is the last cycle of the note.
  // 4-bit beats times 32-bit ticks fits in 36 bits without overflow.
  function automatic logic [35:0] note_load(input logic [3:0] beats);
    return ({32'd0, beats} * {4'd0, BEAT_TICKS}) - 36'd1;
  endfunction

  // Pattern RAM: written on any cycle and never reset. The player reads it
  // only when a note starts, so a write to the entry that is playing takes
  // effect the next time that entry is fetched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_tone[wr_addr]  <= wr_tone;
      ram_beats[wr_addr] <= wr_beats;
    end
  end

  // Clamp the requested length to the RAM depth. Zero passes through
  // unchanged so that start can report an empty sequence.
  always_comb begin
    len_clamped = length;
    if (length > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  // The sequence ends after the current entry when it reaches the played
  // length or the next entry is an end marker (beats == 0).
  assign next_step = step + 4'd1;
  assign is_last   = ({1'b0, step} == (play_len - 5'd1)) || (ram_beats[next_step] == 4'd0);

  // The advance decision is taken on the last gap cycle. With no gap it is
  // taken on the last note cycle, so notes run back to back.
  assign note_end    = (state == PLAY) && (counter == 36'd0);
  assign advance_now = (note_end && !HAS_GAP) || ((state == GAP) && (counter == 36'd0));

  // Choose where playback goes after the current entry. Looping back to
  // entry 0 requires entry 0 to hold a real note; otherwise the sequence ends.
  always_comb begin
    adv_continue = 1'b0;
    adv_step     = next_step;
    if (!is_last) begin
      adv_continue = 1'b1;
    end else if (loop_en && (ram_beats[0] != 4'd0)) begin
      adv_continue = 1'b1;
      adv_step     = 4'd0;
    end
  end

  // Playback state machine. All outputs are registered here. stop has top
  // priority and leaves step and tone at their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= 36'd0;
      play_len <= 5'd0;
      tone     <= 4'd0;
      note_on  <= 1'b0;
      busy     <= 1'b0;
      step     <= 4'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        counter <= 36'd0;
        note_on <= 1'b0;
        busy    <= 1'b0;
      end else if (advance_now) begin
        if (adv_continue) begin
          state   <= PLAY;
          step    <= adv_step;
          tone    <= ram_tone[adv_step];
          counter <= note_load(ram_beats[adv_step]);
          note_on <= 1'b1;
        end else begin
          state   <= IDLE;
          counter <= 36'd0;
          note_on <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if ((len_clamped != 5'd0) && (ram_beats[0] != 4'd0)) begin
                state    <= PLAY;
                play_len <= len_clamped;
                step     <= 4'd0;
                tone     <= ram_tone[0];
                counter  <= note_load(ram_beats[0]);
                note_on  <= 1'b1;
                busy     <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          PLAY: begin
            // Reaching zero here implies a nonzero gap; the no-gap case
            // is handled by the advance branch above.
            if (counter != 36'd0) begin
              counter <= counter - 36'd1;
            end else begin
              state   <= GAP;
              counter <= GAP_LOAD;
              note_on <= 1'b0;
            end
          end
          GAP: begin
            counter <= counter - 36'd1;
          end
          default: begin
            state   <= IDLE;
            counter <= 36'd0;
            note_on <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
//
// Directed bench for melody_sequencer with BEAT_TICKS=4. The main instance
// uses GAP_TICKS=2 and a second instance uses GAP_TICKS=0 for back-to-back
// notes. Both instances share all inputs.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_tone;
  logic [3:0] wr_beats;
  logic [4:0] length;
  logic       loop_en;
  logic       start;
  logic       stop;

  logic [3:0] tone;
  logic       note_on;
  logic       busy;
  logic [3:0] step;
  logic       done;

  logic [3:0] ng_tone;
  logic       ng_note_on;
  logic       ng_busy;
  logic [3:0] ng_step;
  logic       ng_done;

  int checks = 0;
  int errors = 0;

  // Free-running clock with a 10 time-unit period.
  always #5 clk = ~clk;

  melody_sequencer #(
    .BEAT_TICKS(32'd4),
    .GAP_TICKS (32'd2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_tone (wr_tone),
    .wr_beats(wr_beats),
    .length  (length),
    .loop_en (loop_en),
    .start   (start),
    .stop    (stop),
    .tone    (tone),
    .note_on (note_on),
    .busy    (busy),
    .step    (step),
    .done    (done)
  );

  melody_sequencer #(
    .BEAT_TICKS(32'd4),
    .GAP_TICKS (32'd0)
  ) dut_ng (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_tone (wr_tone),
    .wr_beats(wr_beats),
    .length  (length),
    .loop_en (loop_en),
    .start   (start),
    .stop    (stop),
    .tone    (ng_tone),
    .note_on (ng_note_on),
    .busy    (ng_busy),
    .step    (ng_step),
    .done    (ng_done)
  );

  // Compares one observed value against its expected value and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advances to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output of the main instance in one go.
  task automatic checkState(input string tag, input logic exp_on, input logic [3:0] exp_tone,
                            input logic [3:0] exp_step, input logic exp_busy, input logic exp_done);
    checkOutput({tag, ".note_on"}, 32'(note_on), 32'(exp_on));
    checkOutput({tag, ".tone"},    32'(tone),    32'(exp_tone));
    checkOutput({tag, ".step"},    32'(step),    32'(exp_step));
    checkOutput({tag, ".busy"},    32'(busy),    32'(exp_busy));
    checkOutput({tag, ".done"},    32'(done),    32'(exp_done));
  endtask

  // Checks n consecutive busy cycles with constant note_on/tone/step.
  task automatic expectRun(input string tag, input int n, input logic exp_on,
                           input logic [3:0] exp_tone, input logic [3:0] exp_step);
    for (int i = 0; i < n; i++) begin
      checkState(tag, exp_on, exp_tone, exp_step, 1'b1, 1'b0);
      tick();
    end
  endtask

  // Pulses start and/or stop for exactly one clock cycle.
  task automatic applyStimulus(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Writes one pattern entry.
  task automatic writeEntry(input logic [3:0] addr, input logic [3:0] t, input logic [3:0] b);
    wr_en    = 1'b1;
    wr_addr  = addr;
    wr_tone  = t;
    wr_beats = b;
    tick();
    wr_en    = 1'b0;
  endtask

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_tone  = 4'd0;
    wr_beats = 4'd0;
    length   = 5'd0;
    loop_en  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    writeEntry(4'd0, 4'd0, 4'd1);
    writeEntry(4'd1, 4'd2, 4'd2);
    writeEntry(4'd2, 4'd3, 4'd1);

    length  = 5'd3;
    loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    expectRun("c2_e0", 4, 1'b1, 4'd0, 4'd0);
    expectRun("c2_g0", 2, 1'b0, 4'd0, 4'd0);
    expectRun("c2_e1", 8, 1'b1, 4'd2, 4'd1);
    expectRun("c2_g1", 2, 1'b0, 4'd2, 4'd1);
    expectRun("c2_e2", 4, 1'b1, 4'd3, 4'd2);
    expectRun("c2_g2", 2, 1'b0, 4'd3, 4'd2);
    checkState("c2_done", 1'b0, 4'd3, 4'd2, 1'b0, 1'b1);
    tick();
    checkState("c2_after", 1'b0, 4'd3, 4'd2, 1'b0, 1'b0);

    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    expectRun("c3_e0", 4, 1'b1, 4'd0, 4'd0);
    expectRun("c3_g0", 2, 1'b0, 4'd0, 4'd0);
    expectRun("c3_e1", 8, 1'b1, 4'd2, 4'd1);
    expectRun("c3_g1", 2, 1'b0, 4'd2, 4'd1);
    expectRun("c3_e2", 4, 1'b1, 4'd3, 4'd2);
    expectRun("c3_g2", 2, 1'b0, 4'd3, 4'd2);
    expectRun("c3_loop_e0", 4, 1'b1, 4'd0, 4'd0);
    expectRun("c3_loop_g0", 2, 1'b0, 4'd0, 4'd0);
    expectRun("c3_loop_e1a", 3, 1'b1, 4'd2, 4'd1);
    loop_en = 1'b0;
    expectRun("c3_loop_e1b", 5, 1'b1, 4'd2, 4'd1);
    expectRun("c3_loop_g1", 2, 1'b0, 4'd2, 4'd1);
    expectRun("c3_loop_e2", 4, 1'b1, 4'd3, 4'd2);
    expectRun("c3_loop_g2", 2, 1'b0, 4'd3, 4'd2);
    checkState("c3_done", 1'b0, 4'd3, 4'd2, 1'b0, 1'b1);
    tick();

    writeEntry(4'd1, 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b0);
    expectRun("c4_e0", 4, 1'b1, 4'd0, 4'd0);
    expectRun("c4_g0", 2, 1'b0, 4'd0, 4'd0);
    checkState("c4_done", 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    checkState("c4_after", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    writeEntry(4'd0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0);
    checkState("c4_empty", 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    checkState("c4_empty_after", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    writeEntry(4'd0, 4'd0, 4'd1);
    writeEntry(4'd1, 4'd2, 4'd2);

    applyStimulus(1'b1, 1'b0);
    expectRun("c5_e0", 4, 1'b1, 4'd0, 4'd0);
    expectRun("c5_g0", 2, 1'b0, 4'd0, 4'd0);
    expectRun("c5_e1", 1, 1'b1, 4'd2, 4'd1);
    applyStimulus(1'b0, 1'b1);
    checkState("c5_stop", 1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
    tick();
    checkState("c5_nodone", 1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expectRun("c5_restart", 4, 1'b1, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1);
    checkState("c6_startstop", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    checkState("c6_startstop2", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0);
    expectRun("c6_busy_a", 2, 1'b1, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0);
    expectRun("c6_busy_b", 1, 1'b1, 4'd0, 4'd0);
    expectRun("c6_busy_g0", 2, 1'b0, 4'd0, 4'd0);
    expectRun("c6_busy_e1", 8, 1'b1, 4'd2, 4'd1);
    expectRun("c6_busy_g1", 2, 1'b0, 4'd2, 4'd1);
    expectRun("c6_busy_e2", 4, 1'b1, 4'd3, 4'd2);
    expectRun("c6_busy_g2", 2, 1'b0, 4'd3, 4'd2);
    checkState("c6_busy_done", 1'b0, 4'd3, 4'd2, 1'b0, 1'b1);
    tick();

    length = 5'd0;
    applyStimulus(1'b1, 1'b0);
    checkState("c6_len0", 1'b0, 4'd3, 4'd2, 1'b0, 1'b1);
    tick();
    checkState("c6_len0_after", 1'b0, 4'd3, 4'd2, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      writeEntry(4'(i), 4'(i), 4'd1);
    end
    length = 5'd20;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      expectRun("c6_len20_note", 4, 1'b1, 4'(i), 4'(i));
      expectRun("c6_len20_gap", 2, 1'b0, 4'(i), 4'(i));
    end
    checkState("c6_len20_done", 1'b0, 4'd15, 4'd15, 1'b0, 1'b1);
    tick();

    applyStimulus(1'b0, 1'b1);
    writeEntry(4'd0, 4'd0, 4'd1);
    writeEntry(4'd1, 4'd2, 4'd2);
    writeEntry(4'd2, 4'd3, 4'd1);
    length  = 5'd3;
    loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      checkOutput("ng.note_on", 32'(ng_note_on), 32'd1);
      checkOutput("ng.busy", 32'(ng_busy), 32'd1);
      checkOutput("ng.tone", 32'(ng_tone), (c < 4) ? 32'd0 : ((c < 12) ? 32'd2 : 32'd3));
      checkOutput("ng.step", 32'(ng_step), (c < 4) ? 32'd0 : ((c < 12) ? 32'd1 : 32'd2));
      tick();
    end
    checkOutput("ng.end_done", 32'(ng_done), 32'd1);
    checkOutput("ng.end_note_on", 32'(ng_note_on), 32'd0);
    checkOutput("ng.end_busy", 32'(ng_busy), 32'd0);

    applyStimulus(1'b0, 1'b1);
    writeEntry(4'd0, 4'd9, 4'd2);
    applyStimulus(1'b1, 1'b0);
    expectRun("c1_pre", 2, 1'b1, 4'd9, 4'd0);
    rst_n = 1'b0;
    #2;
    checkState("c1_async", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("c1_async.ng_busy", 32'(ng_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
